// File: rtl/hazard_forward_unit_if.sv
// Bundle of ID/IE/EM/MW pipeline-side signals seen by the hazard/forwarding unit.
//   master : pipeline side. It drives the stage addresses, write enables and
//            multi-cycle issue, and receives the selects and the stall.
//   slave  : hazard_forward_unit.
// Source address vectors are flat. Port p sits at [p*ADDR_W +: ADDR_W].
// fw_sel carries port p at [2*p +: 2].
interface hazard_forward_unit_if #(
    parameter int ADDR_W = 5,
    parameter int NPORTS = 2
);
    logic [NPORTS*ADDR_W-1:0] id_src;
    logic [NPORTS-1:0]        id_src_used;
    logic [ADDR_W-1:0]        id_wbaddr;
    logic                     id_regwrite;
    logic                     id_mc;
    logic [NPORTS*ADDR_W-1:0] ie_src;
    logic [ADDR_W-1:0]        ie_wbaddr;
    logic                     ie_regwrite;
    logic                     ie_memread;
    logic [ADDR_W-1:0]        em_wbaddr;
    logic                     em_regwrite;
    logic [ADDR_W-1:0]        mw_wbaddr;
    logic                     mw_regwrite;
    logic                     mc_start;
    logic [ADDR_W-1:0]        mc_dest;
    logic [2*NPORTS-1:0]      fw_sel;
    logic                     stall;
    logic                     mc_busy;
    logic                     mc_done;

    modport master (
        output id_src, id_src_used, id_wbaddr, id_regwrite, id_mc,
        output ie_src, ie_wbaddr, ie_regwrite, ie_memread,
        output em_wbaddr, em_regwrite, mw_wbaddr, mw_regwrite,
        output mc_start, mc_dest,
        input  fw_sel, stall, mc_busy, mc_done
    );

    modport slave (
        input  id_src, id_src_used, id_wbaddr, id_regwrite, id_mc,
        input  ie_src, ie_wbaddr, ie_regwrite, ie_memread,
        input  em_wbaddr, em_regwrite, mw_wbaddr, mw_regwrite,
        input  mc_start, mc_dest,
        output fw_sel, stall, mc_busy, mc_done
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// Forwarding / hazard unit for the 5-stage pipeline.
//   clk, rst : clock; synchronous active-high reset.
//   bus      : hazard_forward_unit_if.slave. Its outputs are:
//              fw_sel   per-port IE operand select
//                       (0 regfile, 1 EM, 2 MW, 3 multi-cycle result)
//              stall    hold PC and IF/ID, and bubble IE
//              mc_busy  a multi-cycle op is in flight
//              mc_done  one-cycle pulse in the multi-cycle writeback cycle
// Register 0 is hardwired, so it never matches for forwarding or stalling.

// Per-operand matcher. It picks the IE bypass source and reports the ID-side
// matches that feed the stall OR.
module hazard_port_match #(
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] id_src,
    input  logic              id_used,
    input  logic [ADDR_W-1:0] ie_src,
    input  logic [ADDR_W-1:0] ie_wbaddr,
    input  logic [ADDR_W-1:0] em_wbaddr,
    input  logic              em_regwrite,
    input  logic [ADDR_W-1:0] mw_wbaddr,
    input  logic              mw_regwrite,
    input  logic              mc_done,
    input  logic [ADDR_W-1:0] pend_dest,
    output logic [1:0]        fw_sel,
    output logic              load_hit,
    output logic              pend_hit
);
    logic ie_src_nz;
    assign ie_src_nz = (ie_src != '0);

    // The youngest producer wins. EM holds a newer value than MW. The
    // multi-cycle result comes last, because a later EM/MW write to the same
    // register supersedes it.
    always_comb begin
        fw_sel = 2'd0;
        if (ie_src_nz && em_regwrite && (em_wbaddr == ie_src))
            fw_sel = 2'd1;
        else if (ie_src_nz && mw_regwrite && (mw_wbaddr == ie_src))
            fw_sel = 2'd2;
        else if (ie_src_nz && mc_done && (pend_dest == ie_src))
            fw_sel = 2'd3;
    end

    // Register-0 and load/busy qualification is applied once at the top level.
    assign load_hit = id_used && (id_src == ie_wbaddr);
    assign pend_hit = id_used && (id_src == pend_dest);
endmodule

module hazard_forward_unit #(
    parameter int ADDR_W = 5,
    parameter int NPORTS = 2,
    parameter int MC_LAT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    hazard_forward_unit_if.slave  bus
);
    localparam int CNT_W = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MC_LAT - 1);

    // Multi-cycle scoreboard state.
    logic              mc_busy;
    logic              mc_done;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] pend_dest;

    logic                   last_cycle;
    logic [NPORTS-1:0][1:0] fw_vec;
    logic [NPORTS-1:0]      load_hit;
    logic [NPORTS-1:0]      pend_hit;

    // cnt==1 while busy marks the final busy cycle. The result lands on the
    // next edge, so that is the cycle in which done rises and busy drops.
    assign last_cycle = mc_busy && (cnt == CNT_ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            mc_busy   <= 1'b0;
            mc_done   <= 1'b0;
            cnt       <= '0;
            pend_dest <= '0;
        end else begin
            mc_done <= last_cycle;
            // A start is accepted only when idle. The done cycle counts as
            // idle, so a back-to-back issue proceeds without a gap.
            if (!mc_busy && bus.mc_start) begin
                mc_busy   <= 1'b1;
                cnt       <= CNT_INIT;
                pend_dest <= bus.mc_dest;
            end else if (mc_busy) begin
                cnt <= cnt - CNT_ONE;
                if (cnt == CNT_ONE)
                    mc_busy <= 1'b0;
            end
        end
    end

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        hazard_port_match #(.ADDR_W(ADDR_W)) u_match (
            .id_src      (bus.id_src[p*ADDR_W +: ADDR_W]),
            .id_used     (bus.id_src_used[p]),
            .ie_src      (bus.ie_src[p*ADDR_W +: ADDR_W]),
            .ie_wbaddr   (bus.ie_wbaddr),
            .em_wbaddr   (bus.em_wbaddr),
            .em_regwrite (bus.em_regwrite),
            .mw_wbaddr   (bus.mw_wbaddr),
            .mw_regwrite (bus.mw_regwrite),
            .mc_done     (mc_done),
            .pend_dest   (pend_dest),
            .fw_sel      (fw_vec[p]),
            .load_hit    (load_hit[p]),
            .pend_hit    (pend_hit[p])
        );
    end

    logic pend_nz;
    logic stall_load, stall_raw, stall_waw, stall_struct;

    assign pend_nz = (pend_dest != '0);

    // A loaded value reaches the bypass network one stage too late for the
    // instruction directly behind it.
    assign stall_load = bus.ie_memread && bus.ie_regwrite &&
                        (bus.ie_wbaddr != '0) && (|load_hit);
    // The pending result only becomes forwardable in the done cycle.
    assign stall_raw  = mc_busy && pend_nz && (|pend_hit);
    // A younger write must not land before the multi-cycle writeback.
    assign stall_waw  = mc_busy && bus.id_regwrite && pend_nz &&
                        (bus.id_wbaddr == pend_dest);
    // The unit is free for a new op once the current one is in its last
    // busy cycle. The next cycle is the done cycle, where a start is taken.
    assign stall_struct = bus.id_mc && mc_busy && (cnt != CNT_ONE);

    assign bus.stall   = stall_load | stall_raw | stall_waw | stall_struct;
    assign bus.fw_sel  = fw_vec;
    assign bus.mc_busy = mc_busy;
    assign bus.mc_done = mc_done;
endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;
    localparam int ADDR_W = 5;
    localparam int NPORTS = 2;
    localparam int MC_LAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hazard_forward_unit_if #(.ADDR_W(ADDR_W), .NPORTS(NPORTS)) ifc ();

    hazard_forward_unit #(.ADDR_W(ADDR_W), .NPORTS(NPORTS), .MC_LAT(MC_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model. age counts the edges since the multi-cycle start was
    // accepted, and is -1 when nothing is tracked.
    int              age = -1;
    logic [ADDR_W-1:0] m_pend = '0;

    function automatic logic m_busy();
        return (age >= 0) && (age <= MC_LAT - 2);
    endfunction
    function automatic logic m_done();
        return age == MC_LAT - 1;
    endfunction
    function automatic logic m_last();
        return age == MC_LAT - 2;
    endfunction

    function automatic logic [2*NPORTS-1:0] exp_fw();
        logic [2*NPORTS-1:0] r;
        logic [ADDR_W-1:0] s;
        r = '0;
        for (int p = 0; p < NPORTS; p++) begin
            s = ifc.ie_src[p*ADDR_W +: ADDR_W];
            if (s == 0)                                       r[2*p +: 2] = 2'd0;
            else if (ifc.em_regwrite && ifc.em_wbaddr == s)   r[2*p +: 2] = 2'd1;
            else if (ifc.mw_regwrite && ifc.mw_wbaddr == s)   r[2*p +: 2] = 2'd2;
            else if (m_done() && m_pend == s)                 r[2*p +: 2] = 2'd3;
        end
        return r;
    endfunction

    function automatic logic exp_stall();
        logic st;
        logic [ADDR_W-1:0] s;
        st = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin
            s = ifc.id_src[p*ADDR_W +: ADDR_W];
            if (ifc.id_src_used[p]) begin
                if (ifc.ie_memread && ifc.ie_regwrite && ifc.ie_wbaddr != 0 && s == ifc.ie_wbaddr)
                    st = 1'b1;
                if (m_busy() && m_pend != 0 && s == m_pend)
                    st = 1'b1;
            end
        end
        if (m_busy() && ifc.id_regwrite && m_pend != 0 && ifc.id_wbaddr == m_pend) st = 1'b1;
        if (ifc.id_mc && m_busy() && !m_last()) st = 1'b1;
        return st;
    endfunction

    // Advance one clock edge, and update the model from the inputs presented
    // before that edge.
    task automatic step();
        int nxt;
        logic [ADDR_W-1:0] np;
        nxt = age;
        np  = m_pend;
        if (rst) begin
            nxt = -1;
            np  = '0;
        end else if (ifc.mc_start && !m_busy()) begin
            nxt = 0;
            np  = ifc.mc_dest;
        end else if (age >= 0) begin
            nxt = age + 1;
            if (nxt > MC_LAT - 1) nxt = -1;
        end
        @(posedge clk);
        age    = nxt;
        m_pend = np;
        #1;
    endtask

    task automatic clear_inputs();
        ifc.id_src = '0; ifc.id_src_used = '0; ifc.id_wbaddr = '0;
        ifc.id_regwrite = 0; ifc.id_mc = 0;
        ifc.ie_src = '0; ifc.ie_wbaddr = '0; ifc.ie_regwrite = 0; ifc.ie_memread = 0;
        ifc.em_wbaddr = '0; ifc.em_regwrite = 0; ifc.mw_wbaddr = '0; ifc.mw_regwrite = 0;
        ifc.mc_start = 0; ifc.mc_dest = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        step();
        rst = 0;
        #1;
        n_checks++; if (ifc.mc_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", ifc.mc_busy); else n_pass++;
        n_checks++; if (ifc.mc_done !== 1'b0) $display("FAIL reset_done got=%b exp=0", ifc.mc_done); else n_pass++;
        n_checks++; if (ifc.stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", ifc.stall); else n_pass++;
        n_checks++; if (ifc.fw_sel !== 4'b0000) $display("FAIL reset_fw got=%b exp=0000", ifc.fw_sel); else n_pass++;
    endtask

    task automatic test_forward();
        clear_inputs();
        ifc.em_regwrite = 1; ifc.em_wbaddr = 5;
        ifc.mw_regwrite = 1; ifc.mw_wbaddr = 5;
        ifc.ie_src = {5'd0, 5'd5};
        #1;
        n_checks++; if (ifc.fw_sel !== 4'b0001) $display("FAIL fw_em_prio got=%b exp=0001", ifc.fw_sel); else n_pass++;
        ifc.em_wbaddr = 0; ifc.ie_src = {5'd0, 5'd0};
        #1;
        n_checks++; if (ifc.fw_sel !== 4'b0000) $display("FAIL fw_r0 got=%b exp=0000", ifc.fw_sel); else n_pass++;
        ifc.ie_src = {5'd5, 5'd5};
        #1;
        n_checks++; if (ifc.fw_sel !== 4'b1010) $display("FAIL fw_mw_both got=%b exp=1010", ifc.fw_sel); else n_pass++;
        ifc.em_regwrite = 0; ifc.em_wbaddr = 3; ifc.mw_wbaddr = 3; ifc.ie_src = {5'd3, 5'd7};
        #1;
        n_checks++; if (ifc.fw_sel !== 4'b1000) $display("FAIL fw_em_disabled got=%b exp=1000", ifc.fw_sel); else n_pass++;
    endtask

    task automatic test_load_use();
        clear_inputs();
        ifc.ie_memread = 1; ifc.ie_regwrite = 1; ifc.ie_wbaddr = 8;
        ifc.id_src = {5'd8, 5'd3}; ifc.id_src_used = 2'b10;
        #1;
        n_checks++; if (ifc.stall !== 1'b1) $display("FAIL load_use got=%b exp=1", ifc.stall); else n_pass++;
        step();
        // The bubble now occupies IE.
        ifc.ie_memread = 0; ifc.ie_regwrite = 0; ifc.ie_wbaddr = 0;
        #1;
        n_checks++; if (ifc.stall !== 1'b0) $display("FAIL load_use_release got=%b exp=0", ifc.stall); else n_pass++;
        ifc.ie_memread = 1; ifc.ie_regwrite = 1; ifc.ie_wbaddr = 8;
        ifc.id_src = {5'd8, 5'd8}; ifc.id_src_used = 2'b00;
        #1;
        n_checks++; if (ifc.stall !== 1'b0) $display("FAIL load_unused got=%b exp=0", ifc.stall); else n_pass++;
        ifc.ie_wbaddr = 0; ifc.id_src = '0; ifc.id_src_used = 2'b11;
        #1;
        n_checks++; if (ifc.stall !== 1'b0) $display("FAIL load_r0 got=%b exp=0", ifc.stall); else n_pass++;
    endtask

    task automatic test_mc_latency();
        clear_inputs();
        ifc.mc_start = 1; ifc.mc_dest = 9;
        step();
        ifc.mc_start = 0;
        for (int c = 0; c < MC_LAT - 1; c++) begin
            ifc.id_src = {5'd0, 5'd9}; ifc.id_src_used = 2'b01;
            #1;
            n_checks++; if (ifc.mc_busy !== 1'b1 || ifc.mc_done !== 1'b0)
                $display("FAIL mc_busy_c%0d got=%b%b exp=10", c, ifc.mc_busy, ifc.mc_done); else n_pass++;
            n_checks++; if (ifc.stall !== 1'b1) $display("FAIL mc_raw_c%0d got=%b exp=1", c, ifc.stall); else n_pass++;
            step();
        end
        ifc.ie_src = {5'd0, 5'd9};
        #1;
        n_checks++; if (ifc.mc_busy !== 1'b0 || ifc.mc_done !== 1'b1)
            $display("FAIL mc_done got=%b%b exp=01", ifc.mc_busy, ifc.mc_done); else n_pass++;
        n_checks++; if (ifc.fw_sel[1:0] !== 2'd3) $display("FAIL mc_fw got=%0d exp=3", ifc.fw_sel[1:0]); else n_pass++;
        n_checks++; if (ifc.stall !== 1'b0) $display("FAIL mc_raw_done got=%b exp=0", ifc.stall); else n_pass++;
        step();
        n_checks++; if (ifc.mc_done !== 1'b0 || ifc.fw_sel[1:0] !== 2'd0)
            $display("FAIL mc_done_pulse got=%b/%0d exp=0/0", ifc.mc_done, ifc.fw_sel[1:0]); else n_pass++;
    endtask

    task automatic test_waw_struct_reset();
        clear_inputs();
        ifc.mc_start = 1; ifc.mc_dest = 9;
        step();
        ifc.mc_start = 0;
        ifc.id_regwrite = 1; ifc.id_wbaddr = 9;
        #1;
        n_checks++; if (ifc.stall !== 1'b1) $display("FAIL waw got=%b exp=1", ifc.stall); else n_pass++;
        ifc.id_regwrite = 0; ifc.id_wbaddr = 0;
        step();
        ifc.id_mc = 1;
        #1;
        n_checks++; if (ifc.stall !== 1'b1) $display("FAIL struct_cnt2 got=%b exp=1", ifc.stall); else n_pass++;
        step();
        #1;
        n_checks++; if (ifc.stall !== 1'b0) $display("FAIL struct_cnt1 got=%b exp=0", ifc.stall); else n_pass++;
        step();
        ifc.id_mc = 0; ifc.mc_start = 1; ifc.mc_dest = 12;
        #1;
        n_checks++; if (ifc.mc_done !== 1'b1) $display("FAIL b2b_done got=%b exp=1", ifc.mc_done); else n_pass++;
        step();
        ifc.mc_start = 0;
        #1;
        n_checks++; if (ifc.mc_busy !== 1'b1) $display("FAIL b2b_accept got=%b exp=1", ifc.mc_busy); else n_pass++;
        step();
        // Reset with cnt==2 in flight abandons the op.
        rst = 1;
        step();
        rst = 0;
        ifc.id_src = {5'd0, 5'd12}; ifc.id_src_used = 2'b01;
        for (int c = 0; c < MC_LAT; c++) begin
            #1;
            n_checks++; if (ifc.mc_busy !== 1'b0 || ifc.mc_done !== 1'b0 || ifc.stall !== 1'b0)
                $display("FAIL rst_mid_c%0d got=%b%b%b exp=000", c, ifc.mc_busy, ifc.mc_done, ifc.stall); else n_pass++;
            step();
        end
    endtask

    task automatic test_r0_dest();
        clear_inputs();
        ifc.mc_start = 1; ifc.mc_dest = 0;
        step();
        ifc.mc_start = 0;
        ifc.id_src = '0; ifc.id_src_used = 2'b11; ifc.id_regwrite = 1; ifc.id_wbaddr = 0;
        for (int c = 0; c < MC_LAT - 1; c++) begin
            #1;
            n_checks++; if (ifc.mc_busy !== 1'b1 || ifc.stall !== 1'b0)
                $display("FAIL r0_busy_c%0d got=%b%b exp=10", c, ifc.mc_busy, ifc.stall); else n_pass++;
            step();
        end
        #1;
        n_checks++; if (ifc.mc_done !== 1'b1 || ifc.fw_sel !== 4'b0000)
            $display("FAIL r0_done got=%b/%b exp=1/0000", ifc.mc_done, ifc.fw_sel); else n_pass++;
        step();
    endtask

    task automatic test_random();
        clear_inputs();
        rst = 1;
        step();
        rst = 0;
        for (int i = 0; i < 600; i++) begin
            for (int p = 0; p < NPORTS; p++) begin
                ifc.id_src[p*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 7));
                ifc.ie_src[p*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 7));
            end
            ifc.id_src_used = NPORTS'($urandom);
            ifc.id_wbaddr   = ADDR_W'($urandom_range(0, 7));
            ifc.id_regwrite = 1'($urandom);
            ifc.id_mc       = ($urandom_range(0, 3) == 0);
            ifc.ie_wbaddr   = ADDR_W'($urandom_range(0, 7));
            ifc.ie_regwrite = 1'($urandom);
            ifc.ie_memread  = ($urandom_range(0, 2) == 0);
            ifc.em_wbaddr   = ADDR_W'($urandom_range(0, 7));
            ifc.em_regwrite = 1'($urandom);
            ifc.mw_wbaddr   = ADDR_W'($urandom_range(0, 7));
            ifc.mw_regwrite = 1'($urandom);
            ifc.mc_start    = ($urandom_range(0, 3) == 0);
            ifc.mc_dest     = ADDR_W'($urandom_range(0, 7));
            rst             = ($urandom_range(0, 99) == 0);
            #1;
            n_checks++; if (ifc.fw_sel !== exp_fw())
                $display("FAIL rnd_fw i=%0d got=%b exp=%b", i, ifc.fw_sel, exp_fw()); else n_pass++;
            n_checks++; if (ifc.stall !== exp_stall())
                $display("FAIL rnd_stall i=%0d got=%b exp=%b", i, ifc.stall, exp_stall()); else n_pass++;
            n_checks++; if (ifc.mc_busy !== m_busy() || ifc.mc_done !== m_done())
                $display("FAIL rnd_mc i=%0d got=%b%b exp=%b%b", i, ifc.mc_busy, ifc.mc_done, m_busy(), m_done()); else n_pass++;
            step();
        end
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_mc_latency();
        test_waw_struct_reset();
        test_r0_dest();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
Parametrised next-generation forwarding/hazard unit for the 5-stage MIPS pipeline. Per-operand bypass selection is generalised to NPORTS read ports, and register 0 is excluded from matching. Adds load-use stall detection and a scoreboard/latency counter for one long-latency unit (divider), with forwarding of its completing result. Sits beside the ID/IE pipeline registers; its outputs drive the IE operand muxes and the PC/IF-ID hold logic.

Parameters:
ADDR_W, 5, register address width
NPORTS, 2, number of source operands per instruction
MC_LAT, 4, multi-cycle unit latency in cycles from accepted start to result writeback (>=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_src  in  NPORTS*ADDR_W  ID-stage source addresses; port p at [p*ADDR_W +: ADDR_W]
id_src_used  in  NPORTS  ID source p is actually read
id_wbaddr  in  ADDR_W  ID-stage destination
id_regwrite  in  1  ID instruction writes a register
id_mc  in  1  ID instruction is a multi-cycle op
ie_src  in  NPORTS*ADDR_W  IE-stage source addresses
ie_wbaddr  in  ADDR_W  IE destination
ie_regwrite  in  1  IE instruction writes a register
ie_memread  in  1  IE instruction is a load
em_wbaddr  in  ADDR_W  EM destination
em_regwrite  in  1  EM instruction writes a register
mw_wbaddr  in  ADDR_W  MW destination
mw_regwrite  in  1  MW instruction writes a register
mc_start  in  1  IE issues a multi-cycle op this cycle
mc_dest  in  ADDR_W  destination of the issuing multi-cycle op
fw_sel  out  2*NPORTS  per-port select: 0 regfile, 1 EM ALU result, 2 MW wb data, 3 MC result
stall  out  1  hold PC and IF/ID, inject bubble into IE
mc_busy  out  1  multi-cycle op in flight
mc_done  out  1  one-cycle pulse; MC result written to the regfile this cycle

Behaviour:
- State: mc_busy, cnt[clog2(MC_LAT)], pend_dest[ADDR_W], mc_done. All cleared by rst at the clock edge. fw_sel and stall are combinational.
- Reset: after the rst edge, mc_busy=0, mc_done=0, cnt=0, pend_dest=0. Reset mid-operation abandons the in-flight op with no mc_done pulse.
- Counter:
  - mc_start is accepted only when !mc_busy. Acceptance sets busy, cnt=MC_LAT-1, pend_dest=mc_dest.
  - While busy, cnt decrements each cycle.
  - In the cycle where busy && cnt==1, mc_done is registered to 1 for the next cycle. During that next cycle busy is cleared (busy and done are never both 1).
  - Latency: start accepted at edge N gives mc_done high during cycle N+MC_LAT-1.
  - mc_start while busy is ignored.
  - mc_start in the same cycle mc_done=1 is accepted.
- Forwarding, per port p:
  - Match requires address != 0.
  - Priority: EM (em_regwrite && em_wbaddr==ie_src[p]) gives 1; else MW gives 2; else (mc_done && pend_dest==ie_src[p]) gives 3; else 0.
- Stall is the OR of:
  - (a) Load-use: ie_memread && ie_regwrite && ie_wbaddr!=0 && any p with id_src_used[p] && id_src[p]==ie_wbaddr.
  - (b) RAW on pending: mc_busy && pend_dest!=0 && any used id_src[p]==pend_dest.
  - (c) WAW: mc_busy && id_regwrite && id_wbaddr==pend_dest && pend_dest!=0.
  - (d) Structural: id_mc && mc_busy && !(cnt==1).
- The stall decision uses the current state only.
- Register 0 never forwards and never stalls.

Test Plan:
- Reset then EM writes r5 and MW writes r5, ie_src[0]=5 -> fw_sel[1:0]=1. Same with em_wbaddr=0, ie_src[0]=0 -> fw_sel[1:0]=0.
- IE is a load to r8, ID uses r8 on port 1 only (id_src_used=2'b10) -> stall=1 for exactly one cycle. Repeat with id_src_used=2'b00 -> stall=0.
- MC_LAT=4, mc_start with mc_dest=9 at edge 0 -> mc_busy=1 for cycles 0..2, mc_done=1 in cycle 3. With ie_src[0]=9 in cycle 3 -> fw_sel[1:0]=3.
- While busy, ID reads r9 -> stall=1 until mc_done. ID writes r9 (WAW) -> stall. ID issues id_mc at cnt==2 -> stall; at cnt==1 -> no stall, and start is accepted in the done cycle.
- Assert rst with cnt=2 in flight -> next cycle mc_busy=0, no mc_done pulse, stall=0 for an ID instruction reading r9.
- mc_start with mc_dest=0 -> busy runs its full latency, and no RAW/WAW stall occurs for reads of r0.
